spi_reg_bridge: RTL and testbench
=================================

# spi_reg_bridge

SPI slave that lets the external MCU read and write the video block's configuration registers. It converts MCU SPI transactions into the video register bus (`reg_addr`, `reg_wdata`, `reg_wstrobe`, `reg_rdata`), and sits directly upstream of that bus in the `clk` domain. SPI pins are oversampled in `clk`; no SCK clock domain exists.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on `spi_sck`, `spi_cs_n` and `spi_mosi`; minimum 2.
- `AUTO_INC`, default 1: when set, the address advances by 4 after each data word in a burst.

Ports:
- `clk`  in  1  system clock; the register bus is synchronous to it.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `spi_sck`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
- `spi_cs_n`  in  1  chip select, active low, asynchronous.
- `spi_mosi`  in  1  MCU to FPGA data, MSB first.
- `spi_miso`  out  1  FPGA to MCU data, MSB first.
- `spi_miso_oe`  out  1  output enable for the `spi_miso` pad.
- `reg_addr`  out  6  register byte address; bits [1:0] are always 0.
- `reg_wdata`  out  32  write data; valid when `reg_wstrobe` is high.
- `reg_wstrobe`  out  1  single-cycle write pulse.
- `reg_rdata`  in  32  read data; combinational from `reg_addr`.
- `busy`  out  1  high while a transaction is open (synchronised CS is low).

## Operation
- Frame format: one command byte, then one or more 32-bit data words, all MSB first.
- Command byte fields:
  - bit 7 = write (1) or read (0).
  - bit 6 is reserved and ignored.
  - bits [5:2] = word address; `reg_addr` = {cmd[5:2], 2'b00}.
  - bits [1:0] are ignored.
- Synchronisation: `sck`, `cs_n` and `mosi` each pass through SYNC_STAGES flops. Synchroniser reset values are sck=0, cs_n=1, mosi=0.
- Edge detect: a further flop on synced sck gives single-cycle `sck_rise` and `sck_fall` pulses.
- Bit timing: data is sampled on `sck_rise`. MISO changes on `sck_fall`.
- FSM states:
  - IDLE: synced cs_n high. Counters cleared.
  - Synced cs_n falling moves IDLE to CMD.
  - CMD: 8 `sck_rise` shifts. On the 8th, latch the write flag and `reg_addr`, then go to DATA.
  - DATA: 3-bit bit counter and 2-bit byte counter. After each completed 32-bit word, take the word action (below) and stay in DATA.
  - Synced cs_n high from any state returns to IDLE.
- Write word action: `reg_wdata` <= assembled word; `reg_wstrobe` = 1 for exactly one cycle.
- Read word load: in the cycle after `reg_addr` is updated, load the 32-bit TX shifter from `reg_rdata`. This happens after the command byte and after each word in a read burst.
- Read bit output: each `sck_fall` in DATA drives `spi_miso` <= tx[31], then shifts tx left by one.
- Address advance (AUTO_INC=1): after each word, `reg_addr` <= `reg_addr` + 4, 6-bit wrap (0x3C -> 0x00). With AUTO_INC=0 the address holds.
- MISO enable: `spi_miso_oe` = 1 only in DATA with the write flag clear. Otherwise `spi_miso_oe` = 0 and `spi_miso` = 0.
- Abort: CS deasserting mid-word discards the partial word. No strobe is issued for it, and `reg_wdata` keeps its previous value.
- CS edges: a CS rising and a `sck_rise` in the same cycle gives CS priority and the bit is ignored. Extra SCK edges in IDLE are ignored.
- Reset values: `reg_addr`=0, `reg_wdata`=0, `reg_wstrobe`=0, `spi_miso`=0, `spi_miso_oe`=0, `busy`=0, FSM=IDLE. Asserting reset mid-transaction aborts the transaction. After reset releases, the block waits for a fresh CS falling edge.

## Timing
- Input constraint: SCK high time and low time are each >= SYNC_STAGES+3 `clk` periods. CS setup and hold to SCK are each >= SYNC_STAGES+2 periods.
- Write latency: `reg_wstrobe` is asserted SYNC_STAGES+2 `clk` cycles after the first `clk` edge that samples the 32nd SCK rising edge high.
- Strobe timing: `reg_addr` is stable during the strobe. The address advance takes effect in the cycle after the strobe.
- Read capture: `reg_rdata` is captured 1 cycle after `reg_addr` updates. This is always before the next `sck_fall`, guaranteed by the input constraint.
- Pin delay: `spi_miso` updates SYNC_STAGES+1 cycles after the SCK falling edge at the pin.
- `busy` follows synced cs_n inverted, with 1 cycle of extra latency.

## Test plan
- Write 0x81 (addr 0x00) then 0x8000_0280: one `reg_wstrobe` with `reg_addr`=0x00 and `reg_wdata`=0x8000_0280; `spi_miso_oe` stays 0.
- Read 0x24 (addr 0x24) with `reg_rdata` model returning 0x0000_004F for 0x24: MCU shifts in 0x0000_004F; no strobe.
- Burst write at 0x3C, three words A/B/C, AUTO_INC=1: strobes at 0x3C, 0x00, 0x04 with A, B, C.
- Abort: write command to 0x14, 20 data bits, then CS high: no strobe, `reg_wdata` unchanged, FSM back in IDLE. The next transaction works normally.
- Reset mid-read: assert `reset_n` low after 10 data bits. All outputs reach reset values asynchronously. The following read of 0x20 returns correct data.
- SCK at the minimum legal half-period (SYNC_STAGES+3 clocks): burst read of 4 words at 0x00 returns the data for 0x00, 0x04, 0x08 and 0x0C with no bit slips.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave bridging MCU frames onto the video register bus.
// SPI pins are oversampled in clk; one command byte then 32-bit data words.
module spi_reg_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter bit AUTO_INC    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [5:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wstrobe,
    input  logic [31:0] reg_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] warm_q;

    logic sck_s, cs_s, mosi_s, warm;
    logic sck_d1_q, rise_q, fall_q, cs_d1_q, busy_q;
    logic cs_fall;

    state_t      state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [5:0]  addr_q, addr_d;
    logic        wr_q, wr_d;
    logic        done_q, done_d;
    logic        wstrobe_q, wstrobe_d;
    logic        adv_q, adv_d;
    logic        ld_q, ld_d;
    logic        miso_q, miso_d;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign warm   = warm_q[SYNC_STAGES-1];

    // CS edges only count once the chain holds a real pin sample,
    // so a CS held low through reset never opens a frame.
    assign cs_fall = warm & cs_d1_q & ~cs_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            warm_q      <= '0;
            sck_d1_q    <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            cs_d1_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            sck_d1_q    <= sck_s;
            rise_q      <= sck_s & ~sck_d1_q;
            fall_q      <= ~sck_s & sck_d1_q;
            cs_d1_q     <= warm ? cs_s : 1'b0;
            busy_q      <= ~cs_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            byte_q    <= '0;
            sh_q      <= '0;
            tx_q      <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            wstrobe_q <= 1'b0;
            adv_q     <= 1'b0;
            ld_q      <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            wstrobe_q <= wstrobe_d;
            adv_q     <= adv_d;
            ld_q      <= ld_d;
            miso_q    <= miso_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        done_d    = 1'b0;
        wstrobe_d = done_q & wr_q;
        adv_d     = done_q;
        ld_d      = 1'b0;
        miso_d    = miso_q;

        // Word pipeline: done -> strobe -> address advance -> TX reload.
        if (done_q && wr_q) begin
            wdata_d = sh_q;
        end
        if (adv_q) begin
            if (AUTO_INC) begin
                addr_d = addr_q + 6'd4;
            end
            ld_d = ~wr_q;
        end
        if (ld_q) begin
            tx_d = reg_rdata;
        end

        if (cs_s) begin
            state_d = IDLE;
            bit_d   = '0;
            byte_d  = '0;
            miso_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                        bit_d   = '0;
                        byte_d  = '0;
                    end
                end
                CMD: begin
                    if (rise_q) begin
                        sh_d  = {sh_q[30:0], mosi_s};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            wr_d    = sh_q[6];
                            addr_d  = {sh_q[4:1], 2'b00};
                            ld_d    = ~sh_q[6];
                            byte_d  = '0;
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (rise_q) begin
                        sh_d  = {sh_q[30:0], mosi_s};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            byte_d = byte_q + 2'd1;
                            if (byte_q == 2'd3) begin
                                done_d = 1'b1;
                            end
                        end
                    end
                    if (fall_q && !wr_q) begin
                        miso_d = tx_q[31];
                        tx_d   = {tx_q[30:0], 1'b0};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign spi_miso_oe = (state_q == DATA) & ~wr_q;
    assign spi_miso    = miso_q & spi_miso_oe;
    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign reg_wstrobe = wstrobe_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: an MCU-side SPI driver plus
// scoreboards for register writes and read-back words.
module tb_spi_reg_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wstrobe;
    logic [31:0] reg_rdata;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int hp = 8;
    int wcount = 0;
    int oe_bad = 0;
    logic wr_phase = 1'b0;
    logic prev_stb = 1'b0;

    logic [37:0] sb_w[$];
    logic [31:0] sb_r[$];

    always #5 clk = ~clk;

    spi_reg_bridge #(.SYNC_STAGES(2), .AUTO_INC(1'b1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wstrobe (reg_wstrobe),
        .reg_rdata   (reg_rdata),
        .busy        (busy)
    );

    function automatic logic [31:0] model_rd(input logic [5:0] a);
        if (a == 6'h24) return 32'h0000_004F;
        return {4'hA, a[5:2], 8'h5C ^ {2'b00, a}, ~{a, 2'b01}, 8'h3C};
    endfunction

    assign reg_rdata = model_rd(reg_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [37:0] e;
        if (wr_phase && spi_miso_oe) oe_bad++;
        if (reg_wstrobe) begin
            wcount++;
            chk("stb_width", {31'b0, prev_stb}, 32'd0);
            chk("stb_expected", {31'b0, sb_w.size() != 0}, 32'd1);
            if (sb_w.size() != 0) begin
                e = sb_w.pop_front();
                chk("stb_addr", {26'b0, reg_addr}, {26'b0, e[37:32]});
                chk("stb_data", reg_wdata, e[31:0]);
            end
        end
        prev_stb = reg_wstrobe;
    end

    task automatic bits(input logic [31:0] v, input int n,
                        output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = v[i];
            repeat (hp) @(negedge clk);
            rx = {rx[30:0], spi_miso};
            spi_sck = 1'b1;
            repeat (hp) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_high();
        repeat (hp) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * hp) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] cmd, input int nw,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] rx;
        logic [31:0] wd[4];
        logic [5:0]  a;
        wd = '{w0, w1, w2, w3};
        a = {cmd[5:2], 2'b00};
        wr_phase = cmd[7];
        spi_cs_n = 1'b0;
        bits({24'h0, cmd}, 8, rx);
        for (int k = 0; k < nw; k++) begin
            if (cmd[7]) sb_w.push_back({a, wd[k]});
            else sb_r.push_back(model_rd(a));
            bits(wd[k], 32, rx);
            if (!cmd[7]) chk("rd_data", rx, sb_r.pop_front());
            a = a + 6'd4;
        end
        cs_high();
        wr_phase = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        int wc0;
        repeat (4) @(negedge clk);
        chk("rst_addr", {26'b0, reg_addr}, 32'd0);
        chk("rst_wdata", reg_wdata, 32'd0);
        chk("rst_outs", {28'b0, reg_wstrobe, spi_miso, spi_miso_oe, busy},
            32'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // single write to 0x00
        xfer(8'h81, 1, 32'h8000_0280, 0, 0, 0);
        chk("wr1_count", wcount, 1);

        // single read of 0x24
        xfer(8'h24, 1, 0, 0, 0, 0);
        chk("rd1_nostb", wcount, 1);

        // burst write wrapping 0x3C -> 0x00 -> 0x04
        xfer(8'hBC, 3, 32'hAAAA_5555, 32'h1357_9BDF, 32'hC0FF_EE01, 0);
        chk("burst_count", wcount, 4);
        chk("wr_oe_low", oe_bad, 0);

        // abort a write to 0x14 after 20 data bits
        wr_phase = 1'b1;
        spi_cs_n = 1'b0;
        bits(32'h94, 8, rx);
        bits(32'h000F_0F0F, 20, rx);
        cs_high();
        wr_phase = 1'b0;
        chk("abort_nostb", wcount, 4);
        chk("abort_wdata", reg_wdata, 32'hC0FF_EE01);
        chk("abort_idle", {30'b0, busy, spi_miso_oe}, 32'd0);
        xfer(8'h88, 1, 32'h1234_5678, 0, 0, 0);
        chk("post_abort_count", wcount, 5);

        // reset in the middle of a read of 0x10
        spi_cs_n = 1'b0;
        bits(32'h10, 8, rx);
        bits(32'h0, 10, rx);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", {26'b0, reg_addr}, 32'd0);
        chk("mid_rst_wdata", reg_wdata, 32'd0);
        chk("mid_rst_outs",
            {28'b0, reg_wstrobe, spi_miso, spi_miso_oe, busy}, 32'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        bits(32'h0, 16, rx);
        chk("post_rst_no_frame", {31'b0, spi_miso_oe}, 32'd0);
        chk("post_rst_busy", {31'b0, busy}, 32'd1);
        cs_high();
        chk("post_rst_idle", {31'b0, busy}, 32'd0);
        xfer(8'h20, 1, 0, 0, 0, 0);

        // minimum half-period burst read
        hp = 5;
        wc0 = wcount;
        xfer(8'h00, 4, 0, 0, 0, 0);
        chk("fast_rd_nostb", wcount, wc0);

        chk("final_wcount", wcount, 5);
        chk("sb_w_empty", sb_w.size(), 0);
        chk("sb_r_empty", sb_r.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
